display_contador: RTL and testbench

DISPLAY_CONTADOR -- requirements
Module: display_contador

---
 rtl/display_contador.sv | 101 ++++++++++
 tb/tb_display_contador.sv | 132 +++++++++++++
 2 files changed

// File: rtl/display_contador.sv
// rtl/display_contador.sv - two-digit multiplexed 7-segment display of a captured 0..15 counter value
// Units digit and tens digit alternate every REFRESH_DIV cycles; a zero tens digit is blanked.
module display_contador #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       value_changed
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);

  typedef enum logic {UNITS = 1'b0, TENS = 1'b1} state_t;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     cap;
  logic [RW-1:0]  rcnt;
  logic           rcnt_end;
  logic           capture;
  logic           tens;
  logic [3:0]     units;
  logic [6:0]     seg_nx;
  logic [1:0]     an_nx;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // hold wins over a simultaneous count change
  assign capture  = !hold && (count != cap);
  assign rcnt_end = (rcnt == RLAST);
  assign tens     = (cap >= 4'd10);
  assign units    = tens ? (cap - 4'd10) : cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap           <= 4'd0;
      value_changed <= 1'b0;
    end else begin
      value_changed <= capture;
      if (capture) cap <= count;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          rcnt <= '0;
    else if (rcnt_end) rcnt <= '0;
    else               rcnt <= rcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= UNITS;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rcnt_end) state_nx = (state == UNITS) ? TENS : UNITS;
  end

  always_comb begin
    seg_nx = 7'b0000000;
    an_nx  = 2'b00;
    if (state == UNITS) begin
      an_nx  = 2'b01;
      seg_nx = decode(units);
    end else if (tens) begin
      an_nx  = 2'b10;
      seg_nx = decode(4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= 7'b0000000;
      an  <= 2'b00;
    end else begin
      seg <= seg_nx;
      an  <= an_nx;
    end
  end

endmodule

// File: tb/tb_display_contador.sv
// tb/tb_display_contador.sv - bench for display_contador
// Model derives the digit phase from the edge count since reset and the displayed value from a captured copy.
module tb_display_contador;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count = 4'd0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       value_changed;

  int total = 0;
  int bad = 0;

  display_contador #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .count(count), .hold(hold),
    .seg(seg), .an(an), .value_changed(value_changed)
  );

  always #5 clk = ~clk;

  logic [6:0] dec [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  int         m_cap = 0;
  int         edge_n = 0;
  logic [6:0] exp_seg = 7'd0;
  logic [1:0] exp_an = 2'd0;
  logic       exp_vc = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cap = 0; edge_n = 0; exp_seg = 7'd0; exp_an = 2'd0; exp_vc = 1'b0;
    end else begin
      if (((edge_n / DIV) % 2) == 0) begin
        exp_an  = 2'b01;
        exp_seg = dec[m_cap % 10];
      end else if (m_cap >= 10) begin
        exp_an  = 2'b10;
        exp_seg = dec[1];
      end else begin
        exp_an  = 2'b00;
        exp_seg = 7'd0;
      end
      exp_vc = (!hold) && (int'(count) != m_cap);
      if (exp_vc) m_cap = int'(count);
      edge_n++;
    end
  end

  always @(negedge clk) begin
    total++;
    if (seg !== exp_seg || an !== exp_an || value_changed !== exp_vc) begin
      bad++;
      $display("FAIL model t=%0t seg=%b/%b an=%b/%b vc=%b/%b (actual/required)",
               $time, seg, exp_seg, an, exp_an, value_changed, exp_vc);
    end
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic goto(input int n);
    int guard = 0;
    while (edge_n <= n && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) check("goto_timeout", 10'd1, 10'd0);
  endtask

  initial begin
    #10;
    check("reset_outs", {seg, an, value_changed}, 10'b0);
    #2 rst = 1'b1;
    goto(0);
    check("first_edge", {seg, an, value_changed}, {7'b1111110, 2'b01, 1'b0});
    count = 4'd7;
    goto(1);  check("c7_pulse", {9'd0, value_changed}, 10'd1);
    goto(2);  check("c7_units", {seg, an, value_changed}, {7'b1110000, 2'b01, 1'b0});
    goto(5);  check("c7_blank", {seg, an, value_changed}, {7'b0000000, 2'b00, 1'b0});
    goto(9);  check("c7_units_again", {seg, an, value_changed}, {7'b1110000, 2'b01, 1'b0});
    count = 4'd13;
    goto(11); check("c13_units", {seg, an, value_changed}, {7'b1111001, 2'b01, 1'b0});
    goto(13); check("c13_tens", {seg, an, value_changed}, {7'b0110000, 2'b10, 1'b0});
    count = 4'd15;
    goto(16); check("c15_units", {seg, an, value_changed}, {7'b1011011, 2'b01, 1'b0});
    count = 4'd0;
    goto(17); check("wrap_pulse", {9'd0, value_changed}, 10'd1);
    goto(18); check("wrap_units", {seg, an, value_changed}, {7'b1111110, 2'b01, 1'b0});
    goto(21); check("wrap_blank", {seg, an, value_changed}, {7'b0000000, 2'b00, 1'b0});
    count = 4'd3;
    goto(23);
    hold = 1'b1; count = 4'd9;
    goto(25); check("hold_units", {seg, an, value_changed}, {7'b1111001, 2'b01, 1'b0});
    goto(27); check("hold_nopulse", {9'd0, value_changed}, 10'd0);
    hold = 1'b0;
    goto(28); check("release_pulse", {9'd0, value_changed}, 10'd1);
    goto(32); check("c9_units", {seg, an, value_changed}, {7'b1111011, 2'b01, 1'b0});
    hold = 1'b1; count = 4'd5;
    goto(33); check("hold_prio_nopulse", {9'd0, value_changed}, 10'd0);
    goto(34); check("hold_prio_units", {seg, an, value_changed}, {7'b1111011, 2'b01, 1'b0});
    hold = 1'b0; count = 4'd12;
    goto(36); check("toggle_capture", {seg, an, value_changed}, {7'b0110000, 2'b10, 1'b0});
    goto(37);
    #2 rst = 1'b0;
    #1 check("async_reset", {seg, an, value_changed}, 10'b0);
    count = 4'd0;
    @(negedge clk);
    #2 rst = 1'b1;
    goto(0);
    check("resume_units", {seg, an, value_changed}, {7'b1111110, 2'b01, 1'b0});
    for (int i = 0; i < 12; i++) begin
      count = 4'((i * 7 + 3) % 16);
      hold = (i % 5 == 4);
      goto(edge_n + i % 3);
    end
    hold = 1'b0;
    goto(edge_n + 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
